// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge/long-press detect raw push buttons
module button_conditioner #(
    parameter int NUM_BTN           = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;

    // Two-flop synchronizer per channel, nothing between the stages
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t        state, state_n;
        logic [DW-1:0] dcnt, dcnt_n;
        logic [HW-1:0] hcnt, hcnt_n;
        logic          fired, fired_n;
        logic          level_q, level_n;
        logic          press_q, press_n;
        logic          release_q, release_n;
        logic          long_q, long_n;
        logic          s;

        assign s = sync_b[g];

        // State, counters and registered outputs for this channel
        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= STABLE_LO;
                dcnt      <= '0;
                hcnt      <= '0;
                fired     <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_n;
                dcnt      <= dcnt_n;
                hcnt      <= hcnt_n;
                fired     <= fired_n;
                level_q   <= level_n;
                press_q   <= press_n;
                release_q <= release_n;
                long_q    <= long_n;
            end
        end

        // Debounce FSM plus saturating hold counter; release completion overrides the hold update
        always_comb begin
            state_n   = state;
            dcnt_n    = dcnt;
            hcnt_n    = hcnt;
            fired_n   = fired;
            level_n   = level_q;
            press_n   = 1'b0;
            release_n = 1'b0;
            long_n    = 1'b0;

            // Hold timing runs while the debounced level is high, including a pending release
            if (state == STABLE_HI || state == WAIT_LO) begin
                if (hcnt == H_LAST) begin
                    if (!fired) begin
                        long_n  = 1'b1;
                        fired_n = 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end

            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state_n = WAIT_HI;
                        dcnt_n  = DW'(1);
                    end else begin
                        dcnt_n = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_n = STABLE_LO;
                        dcnt_n  = '0;
                    end else if (dcnt == D_LAST) begin
                        state_n = STABLE_HI;
                        dcnt_n  = '0;
                        hcnt_n  = '0;
                        level_n = 1'b1;
                        press_n = 1'b1;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_n = WAIT_LO;
                        dcnt_n  = DW'(1);
                    end else begin
                        dcnt_n = '0;
                    end
                end
                WAIT_LO: begin
                    // A bounce back to high keeps hcnt and fired so long-press cannot re-arm
                    if (s) begin
                        state_n = STABLE_HI;
                        dcnt_n  = '0;
                    end else if (dcnt == D_LAST) begin
                        state_n   = STABLE_LO;
                        dcnt_n    = '0;
                        level_n   = 1'b0;
                        release_n = 1'b1;
                        fired_n   = 1'b0;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                    end
                end
                default: begin
                    state_n = STABLE_LO;
                    dcnt_n  = '0;
                end
            endcase
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_long[g]    = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int KIND_PRESS = 0;
    localparam int KIND_REL   = 1;
    localparam int KIND_LONG  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc=%0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int ev_key(input ev_t e);
        return e.cyc * 8 + e.ch * 3 + e.kind;
    endfunction

    // Queue an expected pulse 'off' cycles after the current negedge, kept in time order
    task automatic expect_ev(input int ch, input int kind, input int off);
        ev_t e;
        int  pos;
        e.cyc  = cyc + off;
        e.ch   = ch;
        e.kind = kind;
        pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ev_key(exp_q[i]) > ev_key(e)) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every observed pulse must match the oldest expected event
    always @(negedge clk) begin
        for (int ch = 0; ch < NB; ch++) begin
            for (int k = 0; k < 3; k++) begin
                logic hit;
                hit = (k == KIND_PRESS) ? btn_press[ch] :
                      (k == KIND_REL)   ? btn_release[ch] : btn_long[ch];
                if (hit) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'(cyc * 8 + ch * 3 + k), 32'hffff_ffff);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        check("pulse_event", 32'(cyc * 8 + ch * 3 + k), 32'(ev_key(e)));
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        step(3);
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_pulses", 32'({btn_press, btn_release, btn_long}), 32'h0);
        rst = 1'b0;
        step(3);

        // 1: clean press on ch0, held 20 cycles
        btn_raw[0] = 1'b1;
        expect_ev(0, KIND_PRESS, 6);
        expect_ev(0, KIND_LONG, 22);
        step(5);
        check("t1_level_before", 32'(btn_level[0]), 32'h0);
        step(1);
        check("t1_level_at_press", 32'(btn_level[0]), 32'h1);
        step(14);
        check("t1_level_held", 32'(btn_level), 32'h1);
        btn_raw[0] = 1'b0;
        expect_ev(0, KIND_REL, 6);
        step(10);
        check("t1_level_released", 32'(btn_level), 32'h0);

        // 2: bounce rejection then final hold
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                btn_raw[0] = (i != 3);
                step(1);
            end
        end
        check("t2_level_bounce", 32'(btn_level[0]), 32'h0);
        btn_raw[0] = 1'b1;
        expect_ev(0, KIND_PRESS, 6);
        step(8);
        check("t2_level_after", 32'(btn_level[0]), 32'h1);
        btn_raw[0] = 1'b0;
        expect_ev(0, KIND_REL, 6);
        step(10);

        // 3: long press on ch1, twice
        for (int r = 0; r < 2; r++) begin
            btn_raw[1] = 1'b1;
            expect_ev(1, KIND_PRESS, 6);
            expect_ev(1, KIND_LONG, 22);
            step(40);
            check("t3_level_hold", 32'(btn_level), 32'h2);
            btn_raw[1] = 1'b0;
            expect_ev(1, KIND_REL, 6);
            step(10);
        end

        // 4: short press, no long
        btn_raw[0] = 1'b1;
        expect_ev(0, KIND_PRESS, 6);
        step(10);
        btn_raw[0] = 1'b0;
        expect_ev(0, KIND_REL, 6);
        step(12);
        check("t4_level", 32'(btn_level), 32'h0);

        // 5: simultaneous press, ch0 releases alone
        btn_raw = 2'b11;
        expect_ev(0, KIND_PRESS, 6);
        expect_ev(1, KIND_PRESS, 6);
        expect_ev(1, KIND_LONG, 22);
        step(6);
        check("t5_press_both", 32'(btn_press), 32'h3);
        step(6);
        btn_raw[0] = 1'b0;
        expect_ev(0, KIND_REL, 6);
        step(16);
        check("t5_level_split", 32'(btn_level), 32'h2);

        // 6: reset with ch0 in WAIT_HI (dcnt=2) and ch1 in STABLE_HI
        btn_raw[0] = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        check("t6_reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
        rst = 1'b0;
        expect_ev(0, KIND_PRESS, 6);
        expect_ev(1, KIND_PRESS, 6);
        step(6);
        check("t6_repress_both", 32'(btn_press), 32'h3);
        check("t6_level_both", 32'(btn_level), 32'h3);
        step(6);
        btn_raw = 2'b00;
        expect_ev(0, KIND_REL, 6);
        expect_ev(1, KIND_REL, 6);
        step(20);
        check("final_level", 32'(btn_level), 32'h0);
        check("pending_events", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
